// File: rtl/erg_pkg.sv
// rtl/erg_pkg.sv - shared phase type and parameter defaults for the stroke phase detector
package erg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPINUP,
    DRIVE,
    RECOVERY
  } phase_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_PERIOD_W        = 32;
  localparam int DEF_HYST            = 2;
  localparam int DEF_CONFIRM         = 2;
  localparam int DEF_TIMEOUT         = 50_000_000;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - flywheel sensor synchronizer, debounce and rising-edge tick
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sensor_in,
  output logic level,
  output logic tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] stable_cnt;

  // level flips on the DEBOUNCE_CYCLES-th consecutive differing sample; tick marks a rising flip
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
      tick       <= 1'b0;
    end else begin
      sync_1 <= sensor_in;
      sync_2 <= sync_1;
      tick   <= 1'b0;
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level      <= sync_2;
        stable_cnt <= '0;
        tick       <= sync_2;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stroke_phase_detector.sv
// rtl/stroke_phase_detector.sv - classifies flywheel tick periods into drive/recovery phases
module stroke_phase_detector
  import erg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PERIOD_W        = DEF_PERIOD_W,
  parameter int HYST            = DEF_HYST,
  parameter int CONFIRM         = DEF_CONFIRM,
  parameter int TIMEOUT         = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sensor_in,
  output logic                start_drive,
  output logic                start_recovery,
  output logic                on_drive,
  output logic                idle,
  output logic [15:0]         stroke_count,
  output logic [PERIOD_W-1:0] period
);

  localparam int                SW        = $clog2(CONFIRM + 1);
  localparam logic [SW-1:0]     CONFIRM_V = SW'(CONFIRM);
  localparam logic [PERIOD_W:0] HYST_V    = (PERIOD_W + 1)'(HYST);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;

  logic                tick;
  logic                level_unused;
  phase_t              state, state_next;
  logic [PERIOD_W-1:0] cnt;
  logic                have_period;
  logic [SW-1:0]       acc_streak, dec_streak, acc_next, dec_next;
  logic [PERIOD_W:0]   cur_x, prev_x;
  logic                measure, accel, decel;
  logic                drive_p, rec_p, count_inc;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .sensor_in(sensor_in),
    .level    (level_unused),
    .tick     (tick)
  );

  // Streaks are evaluated on their next values so the phase switch lands one cycle after the tick
  always_comb begin
    cur_x   = {1'b0, cnt};
    prev_x  = {1'b0, period};
    measure = tick && (state != IDLE) && have_period;
    accel   = measure && (cur_x + HYST_V < prev_x);
    decel   = measure && (cur_x > prev_x + HYST_V);

    acc_next = acc_streak;
    dec_next = dec_streak;
    if (accel) begin
      acc_next = (acc_streak == CONFIRM_V) ? acc_streak : acc_streak + SW'(1);
      dec_next = '0;
    end else if (decel) begin
      dec_next = (dec_streak == CONFIRM_V) ? dec_streak : dec_streak + SW'(1);
      acc_next = '0;
    end else if (measure) begin
      acc_next = '0;
      dec_next = '0;
    end

    state_next = state;
    drive_p    = 1'b0;
    rec_p      = 1'b0;
    count_inc  = 1'b0;
    case (state)
      IDLE:     if (tick) state_next = SPINUP;
      SPINUP:   if (acc_next == CONFIRM_V) begin
                  state_next = DRIVE;
                  drive_p    = 1'b1;
                end
      DRIVE:    if (dec_next == CONFIRM_V) begin
                  state_next = RECOVERY;
                  rec_p      = 1'b1;
                end
      RECOVERY: if (acc_next == CONFIRM_V) begin
                  state_next = DRIVE;
                  drive_p    = 1'b1;
                  count_inc  = 1'b1;
                end
      default:  state_next = IDLE;
    endcase

    // Timeout out of DRIVE still closes the drive phase for the downstream counter
    if ((state != IDLE) && !tick && (cnt == TIMEOUT_V)) begin
      state_next = IDLE;
      drive_p    = 1'b0;
      rec_p      = (state == DRIVE);
      count_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      period         <= '0;
      have_period    <= 1'b0;
      acc_streak     <= '0;
      dec_streak     <= '0;
      start_drive    <= 1'b0;
      start_recovery <= 1'b0;
      stroke_count   <= '0;
    end else begin
      state          <= state_next;
      start_drive    <= drive_p;
      start_recovery <= rec_p;
      if (count_inc) stroke_count <= stroke_count + 16'd1;

      if (tick) cnt <= PERIOD_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + PERIOD_W'(1);

      if (tick && (state != IDLE)) begin
        period      <= cnt;
        have_period <= 1'b1;
      end
      if (state_next == IDLE) have_period <= 1'b0;

      if (state_next != state) begin
        acc_streak <= '0;
        dec_streak <= '0;
      end else begin
        acc_streak <= acc_next;
        dec_streak <= dec_next;
      end
    end
  end

  assign on_drive = (state == DRIVE);
  assign idle     = (state == IDLE);

endmodule

// File: tb/tb_stroke_phase_detector.sv
// tb/tb_stroke_phase_detector.sv - randomized self-checking bench for stroke_phase_detector
module tb_stroke_phase_detector;

  localparam int DEB = 4;
  localparam int PW  = 32;
  localparam int HY  = 2;
  localparam int CF  = 2;
  localparam int TO  = 1000;
  localparam int LAT = 2 + DEB + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sensor_in = 1'b0;
  logic          start_drive, start_recovery, on_drive, idle;
  logic [15:0]   stroke_count;
  logic [PW-1:0] period;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rise = 0;
  int drv_q[$];
  int rec_q[$];
  bit sd_prev = 1'b0;
  bit sr_prev = 1'b0;

  // Reference model: phase 0 idle, 1 spinup, 2 drive, 3 recovery
  int m_phase = 0;
  int m_last = 0;
  bit m_have = 1'b0;
  int m_acc = 0;
  int m_dec = 0;
  int m_strokes = 0;

  stroke_phase_detector #(
    .DEBOUNCE_CYCLES(DEB),
    .PERIOD_W       (PW),
    .HYST           (HY),
    .CONFIRM        (CF),
    .TIMEOUT        (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sensor_in     (sensor_in),
    .start_drive   (start_drive),
    .start_recovery(start_recovery),
    .on_drive      (on_drive),
    .idle          (idle),
    .stroke_count  (stroke_count),
    .period        (period)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_drive) drv_q.push_back(cyc);
    if (start_recovery) rec_q.push_back(cyc);
    if (start_drive || start_recovery) begin
      n_cmp++;
      if (start_drive && start_recovery) begin
        n_bad++;
        $display("FAIL pulse_exclusive cyc=%0d got drive=1 recovery=1 want at most one", cyc);
      end
      n_cmp++;
      if ((start_drive && sd_prev) || (start_recovery && sr_prev)) begin
        n_bad++;
        $display("FAIL pulse_width cyc=%0d got pulse longer than 1 cycle want 1", cyc);
      end
    end
    sd_prev = start_drive;
    sr_prev = start_recovery;
    cyc++;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog got no finish want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  task automatic model_reset();
    m_phase = 0; m_last = 0; m_have = 0; m_acc = 0; m_dec = 0; m_strokes = 0;
  endtask

  task automatic model_tick(input int sp, output int ev);
    int nxt;
    ev = 0;
    if (m_phase == 0) begin
      m_phase = 1; m_have = 0; m_acc = 0; m_dec = 0;
      return;
    end
    if (m_have) begin
      if (sp + HY < m_last) begin
        m_acc = (m_acc < CF) ? m_acc + 1 : CF; m_dec = 0;
      end else if (sp > m_last + HY) begin
        m_dec = (m_dec < CF) ? m_dec + 1 : CF; m_acc = 0;
      end else begin
        m_acc = 0; m_dec = 0;
      end
    end
    m_last = sp;
    m_have = 1;
    nxt = m_phase;
    if ((m_phase == 1 || m_phase == 3) && m_acc == CF) begin
      nxt = 2; ev = 1;
      if (m_phase == 3) m_strokes = (m_strokes + 1) % 65536;
    end else if (m_phase == 2 && m_dec == CF) begin
      nxt = 3; ev = 2;
    end
    if (nxt != m_phase) begin
      m_acc = 0; m_dec = 0; m_phase = nxt;
    end
  endtask

  // One sensor stroke whose rising edge lands sp cycles after the previous one
  task automatic do_tick(input int sp, input bit glitch);
    int rise, ev, exp_d, exp_r;
    bit first;
    first = (m_phase == 0);
    if (first) begin
      @(posedge clk); #1;
    end else begin
      while (cyc < last_rise + sp) begin
        @(posedge clk); #1;
      end
    end
    rise = cyc;
    last_rise = rise;
    sensor_in = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 12) sensor_in = 1'b0;
      if (glitch && i == 24) sensor_in = 1'b1;
      if (i == 27) sensor_in = 1'b0;
    end
    model_tick(sp, ev);
    exp_d = (ev == 1) ? 1 : 0;
    exp_r = (ev == 2) ? 1 : 0;
    n_cmp++;
    if (drv_q.size() != exp_d) begin
      n_bad++;
      $display("FAIL drive_pulses sp=%0d got %0d want %0d", sp, drv_q.size(), exp_d);
    end else if (exp_d == 1) begin
      n_cmp++;
      if (drv_q[0] != rise + LAT) begin
        n_bad++;
        $display("FAIL drive_latency got cyc %0d want %0d", drv_q[0], rise + LAT);
      end
    end
    n_cmp++;
    if (rec_q.size() != exp_r) begin
      n_bad++;
      $display("FAIL recovery_pulses sp=%0d got %0d want %0d", sp, rec_q.size(), exp_r);
    end else if (exp_r == 1) begin
      n_cmp++;
      if (rec_q[0] != rise + LAT) begin
        n_bad++;
        $display("FAIL recovery_latency got cyc %0d want %0d", rec_q[0], rise + LAT);
      end
    end
    drv_q.delete();
    rec_q.delete();
    if (!first) begin
      n_cmp++;
      if (period !== PW'(sp)) begin
        n_bad++;
        $display("FAIL period got %0d want %0d", period, sp);
      end
    end
    n_cmp++;
    if ({on_drive, idle} !== {(m_phase == 2), 1'b0}) begin
      n_bad++;
      $display("FAIL phase_levels got on_drive=%b idle=%b want on_drive=%b idle=0", on_drive, idle, (m_phase == 2));
    end
    n_cmp++;
    if (stroke_count !== 16'(m_strokes)) begin
      n_bad++;
      $display("FAIL stroke_count got %0d want %0d", stroke_count, m_strokes);
    end
  endtask

  task automatic run_seq(input int seq[$]);
    foreach (seq[i]) do_tick(seq[i], 1'b1);
  endtask

  task automatic check_cleared(input string tag);
    n_cmp++;
    if ({start_drive, start_recovery, on_drive, idle} !== 4'b0001 || stroke_count !== 16'd0 || period !== '0) begin
      n_bad++;
      $display("FAIL %s got sd=%b sr=%b od=%b idle=%b sc=%0d per=%0d want 0,0,0,1,0,0",
               tag, start_drive, start_recovery, on_drive, idle, stroke_count, period);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_cleared("reset_state");
    @(negedge clk) reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    sensor_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    sensor_in = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check_cleared("glitch_no_tick");
    n_cmp++;
    if (drv_q.size() + rec_q.size() != 0) begin
      n_bad++;
      $display("FAIL glitch_pulses got %0d want 0", drv_q.size() + rec_q.size());
    end
    drv_q.delete();
    rec_q.delete();
  endtask

  task automatic test_drive_entry();
    run_seq('{0, 200, 200, 180, 160});
  endtask

  task automatic test_stroke_cycle();
    run_seq('{190, 210, 190, 170});
  endtask

  task automatic test_hysteresis();
    run_seq('{190, 210, 200, 201, 199, 202, 180, 160});
  endtask

  task automatic test_timeout();
    int w = 0;
    int want_rec;
    want_rec = (m_phase == 2) ? 1 : 0;
    while (rec_q.size() == 0 && w < TO + 100) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++;
    if (rec_q.size() != want_rec) begin
      n_bad++;
      $display("FAIL timeout_recovery got %0d pulses want %0d", rec_q.size(), want_rec);
    end else if (want_rec == 1) begin
      n_cmp++;
      if (rec_q[0] != last_rise + LAT + TO) begin
        n_bad++;
        $display("FAIL timeout_latency got cyc %0d want %0d", rec_q[0], last_rise + LAT + TO);
      end
    end
    n_cmp++;
    if (drv_q.size() != 0 || {on_drive, idle} !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_state got drv=%0d od=%b idle=%b want 0,0,1", drv_q.size(), on_drive, idle);
    end
    n_cmp++;
    if (stroke_count !== 16'(m_strokes)) begin
      n_bad++;
      $display("FAIL timeout_stroke_hold got %0d want %0d", stroke_count, m_strokes);
    end
    drv_q.delete();
    rec_q.delete();
    m_phase = 0;
    m_have = 0;
  endtask

  task automatic test_random();
    int sp = 200;
    int dir = 1;
    int run = 0;
    do_tick(0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      if (run == 0) begin
        dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
        run = $urandom_range(1, 5);
      end
      sp = sp + dir * int'($urandom_range(0, 15));
      if (sp < 40) sp = 40;
      if (sp > 400) sp = 400;
      run--;
      do_tick(sp, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_drive();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    model_reset();
    drv_q.delete();
    rec_q.delete();
    run_seq('{0, 200, 200, 180, 160, 190, 210, 190, 170});
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_cleared("async_reset");
    model_reset();
    drv_q.delete();
    rec_q.delete();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    n_cmp++;
    if (drv_q.size() + rec_q.size() != 0 || idle !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset got pulses=%0d idle=%b want 0,1", drv_q.size() + rec_q.size(), idle);
    end
  endtask

  initial begin
    test_reset();
    test_drive_entry();
    test_stroke_cycle();
    test_hysteresis();
    test_timeout();
    test_random();
    test_reset_mid_drive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
